// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    BR_WAIT = 1'b1
  } hz_state_e;

  localparam int WRITE_LATENCY  = 3;
  localparam int BRANCH_RESOLVE = 2;

  // Bits needed to hold a countdown that starts at 'latency'.
  function automatic int sb_cnt_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register countdown scoreboard of in-flight writes
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int selectionBits = 4,
  parameter int writeLatency  = WRITE_LATENCY
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ld_en_i,
  input  logic [selectionBits-1:0]    ld_sel_i,
  input  logic [selectionBits-1:0]    rd_sel1_i,
  input  logic [selectionBits-1:0]    rd_sel2_i,
  output logic [2**selectionBits-1:0] busy_mask_o,
  output logic                        busy1_o,
  output logic                        busy2_o
);

  localparam int NREG = 2 ** selectionBits;
  localparam int CW   = sb_cnt_width(writeLatency);

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];

  // Next count: an issuing writer reloads its destination, everything else counts down to 0.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ld_en_i && (ld_sel_i == selectionBits'(i))) begin
        cnt_d[i] = CW'(writeLatency);
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  // Counter array register; reset drops every pending write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Busy flags come from the pre-update counts, so a count of 1 still reads busy.
  always_comb begin
    for (int i = 0; i < NREG; i++) busy_mask_o[i] = (cnt_q[i] != '0);
  end

  assign busy1_o = (cnt_q[rd_sel1_i] != '0);
  assign busy2_o = (cnt_q[rd_sel2_i] != '0);

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - RAW stall, branch hold/flush and stall statistics
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int selectionBits = 4,
  parameter int writeLatency  = WRITE_LATENCY,
  parameter int branchResolve = BRANCH_RESOLVE,
  parameter int statWidth     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dec_valid,
  input  logic [selectionBits-1:0]    dec_rSel1,
  input  logic [selectionBits-1:0]    dec_rSel2,
  input  logic                        dec_uses1,
  input  logic                        dec_uses2,
  input  logic                        dec_regWrEn,
  input  logic [selectionBits-1:0]    dec_regToWrite,
  input  logic                        dec_isBranch,
  input  logic                        wb_pcWrEn,
  output logic                        stall_fd,
  output logic                        bubble_de,
  output logic                        flush,
  output logic [2**selectionBits-1:0] busy_mask,
  output logic [statWidth-1:0]        stall_cycles
);

  localparam int BW = sb_cnt_width(branchResolve);

  hz_state_e            state_q, state_d;
  logic [BW-1:0]        br_cnt_q, br_cnt_d;
  logic [statWidth-1:0] stall_cycles_q;
  logic                 busy1, busy2;
  logic                 hazard, issue;

  reg_scoreboard #(
    .selectionBits (selectionBits),
    .writeLatency  (writeLatency)
  ) u_scoreboard (
    .clk_i       (clk),
    .rst_ni      (rst),
    .ld_en_i     (issue & dec_regWrEn),
    .ld_sel_i    (dec_regToWrite),
    .rd_sel1_i   (dec_rSel1),
    .rd_sel2_i   (dec_rSel2),
    .busy_mask_o (busy_mask),
    .busy1_o     (busy1),
    .busy2_o     (busy2)
  );

  assign hazard = dec_valid & ((dec_uses1 & busy1) | (dec_uses2 & busy2));
  assign issue  = dec_valid & ~hazard & (state_q == IDLE);

  // Next state and pipe controls; a pending source outranks branch issue.
  always_comb begin
    state_d   = state_q;
    br_cnt_d  = br_cnt_q;
    stall_fd  = 1'b0;
    bubble_de = 1'b0;
    flush     = 1'b0;
    case (state_q)
      IDLE: begin
        stall_fd  = hazard;
        bubble_de = hazard;
        flush     = wb_pcWrEn;
        if (issue && dec_isBranch) begin
          state_d  = BR_WAIT;
          br_cnt_d = BW'(branchResolve);
        end
      end
      BR_WAIT: begin
        stall_fd  = 1'b1;
        bubble_de = 1'b1;
        br_cnt_d  = br_cnt_q - BW'(1);
        if (br_cnt_q == BW'(1)) begin
          state_d = IDLE;
          if (wb_pcWrEn) begin
            flush    = 1'b1;
            stall_fd = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and branch countdown registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      br_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      br_cnt_q <= br_cnt_d;
    end
  end

  // Saturating count of cycles in which fetch/decode was held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
    end else if (stall_fd && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + statWidth'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - randomized self-checking bench for hazard_controller
module tb_hazard_controller;

  localparam int WL     = 3;
  localparam int BRR    = 2;
  localparam int SC_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_uses1, dec_uses2, dec_regWrEn, dec_isBranch, wb_pcWrEn;
  logic [3:0]  dec_rSel1, dec_rSel2, dec_regToWrite;
  logic        stall_fd, bubble_de, flush;
  logic [15:0] busy_mask, stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: remaining cycles per register, cycles since branch issue, stall tally.
  int pend [16];
  int br_age;
  int sc_model;
  logic last_dut_stall;

  hazard_controller dut (
    .clk            (clk),
    .rst            (rst),
    .dec_valid      (dec_valid),
    .dec_rSel1      (dec_rSel1),
    .dec_rSel2      (dec_rSel2),
    .dec_uses1      (dec_uses1),
    .dec_uses2      (dec_uses2),
    .dec_regWrEn    (dec_regWrEn),
    .dec_regToWrite (dec_regToWrite),
    .dec_isBranch   (dec_isBranch),
    .wb_pcWrEn      (wb_pcWrEn),
    .stall_fd       (stall_fd),
    .bubble_de      (bubble_de),
    .flush          (flush),
    .busy_mask      (busy_mask),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) pend[i] = 0;
    br_age   = 0;
    sc_model = 0;
  endtask

  // Called 1 time unit after a rising edge: apply inputs, check at mid-cycle, advance the model.
  task automatic cycle(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic u1, input logic u2, input logic we, input logic [3:0] dst,
                       input logic br, input logic wb);
    logic hz, inw, res, e_stall, e_bub, e_fl, iss;
    logic [15:0] e_mask;
    dec_valid = v; dec_rSel1 = s1; dec_rSel2 = s2; dec_uses1 = u1; dec_uses2 = u2;
    dec_regWrEn = we; dec_regToWrite = dst; dec_isBranch = br; wb_pcWrEn = wb;
    #4;
    hz  = v && ((u1 && pend[s1] > 0) || (u2 && pend[s2] > 0));
    inw = (br_age > 0);
    res = inw && (br_age == BRR);
    e_stall = inw ? !(res && wb) : hz;
    e_bub   = inw ? 1'b1 : hz;
    e_fl    = inw ? (res && wb) : wb;
    for (int i = 0; i < 16; i++) e_mask[i] = (pend[i] > 0);
    check("stall_fd", 32'(stall_fd), 32'(e_stall));
    check("bubble_de", 32'(bubble_de), 32'(e_bub));
    check("flush", 32'(flush), 32'(e_fl));
    check("busy_mask", 32'(busy_mask), 32'(e_mask));
    check("stall_cycles", 32'(stall_cycles), 32'(sc_model));
    last_dut_stall = stall_fd;
    iss = v && !hz && !inw;
    for (int i = 0; i < 16; i++) if (pend[i] > 0) pend[i]--;
    if (iss && we) pend[dst] = WL;
    if (inw) br_age = res ? 0 : br_age + 1;
    else if (iss && br) br_age = 1;
    if (e_stall && sc_model < SC_MAX) sc_model++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without waiting for an edge.
  task automatic mid_reset();
    dec_valid = 1'b1; dec_uses1 = 1'b1; dec_uses2 = 1'b1;
    dec_rSel1 = 4'($urandom); dec_rSel2 = 4'($urandom);
    wb_pcWrEn = 1'b0;
    #1 rst = 1'b0;
    #1;
    model_clear();
    check("rst_stall_fd", 32'(stall_fd), 32'd0);
    check("rst_bubble_de", 32'(bubble_de), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_busy_mask", 32'(busy_mask), 32'd0);
    @(posedge clk);
    #1;
    check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int sc0;
    model_clear();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dec_valid = 1'($urandom); dec_rSel1 = 4'($urandom); dec_rSel2 = 4'($urandom);
      dec_uses1 = 1'($urandom); dec_uses2 = 1'($urandom); dec_regWrEn = 1'($urandom);
      dec_regToWrite = 4'($urandom); dec_isBranch = 1'($urandom); wb_pcWrEn = 1'b0;
      @(posedge clk);
    end
    #1;
    check("reset_stall_fd", 32'(stall_fd), 32'd0);
    check("reset_bubble_de", 32'(bubble_de), 32'd0);
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_busy_mask", 32'(busy_mask), 32'd0);
    check("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    rst = 1'b1;
    idle_cycle();

    // Back-to-back RAW on r3.
    cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      if (!last_dut_stall) break;
      n++;
    end
    check("raw_stall_count", 32'(n), 32'd3);

    // No false stall: other registers, and a matching source that is not read.
    cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    cycle(1'b1, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check("no_false_stall_r5r6", 32'(last_dut_stall), 32'd0);
    cycle(1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("no_stall_unused_src", 32'(last_dut_stall), 32'd0);
    repeat (3) idle_cycle();

    // Taken branch.
    sc0 = sc_model;
    cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    cycle(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle_cycle();
    check("br_taken_stall_cycles", 32'(stall_cycles), 32'(sc0 + 1));

    // Not-taken branch, then the following instruction.
    cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    cycle(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("br_not_taken_issue", 32'(last_dut_stall), 32'd0);

    // Branch reading a pending r2, then reset while it waits for resolution.
    cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
      if (!last_dut_stall) break;
      n++;
    end
    check("br_hazard_wait", 32'(n), 32'd3);
    mid_reset();
    idle_cycle();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_reset();
      end else begin
        cycle(1'($urandom_range(0, 7) != 0), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 7)),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
